median_img_ctrl: RTL and testbench

MEDIAN_IMG_CTRL -- requirements
Module: median_img_ctrl

---
 rtl/median_img_pkg.sv | 20 ++
 rtl/median_img_addr.sv | 77 +++++++
 rtl/median_img_ctrl.sv | 141 ++++++++++++++
 tb/tb_median_img_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/median_img_pkg.sv
// Shared constants and the controller state encoding for the median image filter controller.
package median_img_pkg;

  localparam int SIZE_DEF     = 8;
  localparam int W_DEF        = 16;
  localparam int H_DEF        = 16;
  localparam int ADDR_W_DEF   = 10;
  localparam int DST_BASE_DEF = 256;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    WRITE  = 3'd3,
    BRD_RD = 3'd4,
    BRD_WR = 3'd5,
    FIN    = 3'd6
  } state_t;

endpackage

// File: rtl/median_img_addr.sv
// Raster position counters (x, y, y*W row offset) and 3x3 window address generation.
module median_img_addr
  import median_img_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int H      = H_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              clr,
  input  logic              adv,
  input  logic [3:0]        k,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [ADDR_W-1:0] win_addr,
  output logic              last,
  output logic              next_border
);

  localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(W - 1);
  localparam logic [ADDR_W-1:0] Y_MAX = ADDR_W'(H - 1);
  localparam logic [ADDR_W-1:0] ROW   = ADDR_W'(W);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0] x_r, y_r, row_r;
  logic [ADDR_W-1:0] nx_s, ny_s, wrow_s, wcol_s;
  logic              x_end_s;

  assign x_end_s     = (x_r == X_MAX);
  assign last        = x_end_s && (y_r == Y_MAX);
  assign pix_addr    = row_r + x_r;
  assign next_border = (nx_s == '0) || (nx_s == X_MAX) || (ny_s == '0) || (ny_s == Y_MAX);

  // Position of the pixel that follows the current one in raster order.
  always_comb begin
    nx_s = x_r + ONE;
    ny_s = y_r;
    if (x_end_s) begin
      nx_s = '0;
      ny_s = y_r + ONE;
    end else begin
      nx_s = x_r + ONE;
      ny_s = y_r;
    end
  end

  // Counters; the row offset steps by W on each wrap so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (!nrst || clr) begin
      x_r   <= '0;
      y_r   <= '0;
      row_r <= '0;
    end else if (adv) begin
      x_r   <= nx_s;
      y_r   <= ny_s;
      row_r <= x_end_s ? (row_r + ROW) : row_r;
    end
  end

  // Window element k, row-major from (x-1, y-1) to (x+1, y+1).
  always_comb begin
    wrow_s = row_r;
    wcol_s = x_r;
    case (k)
      4'd0, 4'd1, 4'd2: wrow_s = row_r - ROW;
      4'd6, 4'd7, 4'd8: wrow_s = row_r + ROW;
      default:          wrow_s = row_r;
    endcase
    case (k)
      4'd0, 4'd3, 4'd6: wcol_s = x_r - ONE;
      4'd2, 4'd5, 4'd8: wcol_s = x_r + ONE;
      default:          wcol_s = x_r;
    endcase
    win_addr = wrow_s + wcol_s;
  end

endmodule

// File: rtl/median_img_ctrl.sv
// Whole-image 3x3 median filter sequencer: copies border pixels and streams each
// interior window through an external median unit, writing results at DST_BASE.
module median_img_ctrl
  import median_img_pkg::*;
#(
  parameter int SIZE     = SIZE_DEF,
  parameter int W        = W_DEF,
  parameter int H        = H_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DST_BASE = DST_BASE_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] RADDR,
  input  logic [SIZE-1:0]   RDATA,
  output logic              WE,
  output logic [ADDR_W-1:0] WADDR,
  output logic [SIZE-1:0]   WDATA,
  output logic [SIZE-1:0]   MDI,
  output logic              MDSI,
  input  logic [SIZE-1:0]   MDO,
  input  logic              MDSO
);

  localparam logic [ADDR_W-1:0] DST_A = ADDR_W'(DST_BASE);

  state_t            state_r, state_s;
  logic [3:0]        k_r;
  logic [SIZE-1:0]   res_r;
  logic              clr_s, adv_s, last_s, next_border_s;
  logic [ADDR_W-1:0] pix_s, win_s;

  median_img_addr #(.W(W), .H(H), .ADDR_W(ADDR_W)) u_addr (
    .clk         (CLK),
    .nrst        (nRST),
    .clr         (clr_s),
    .adv         (adv_s),
    .k           (k_r),
    .pix_addr    (pix_s),
    .win_addr    (win_s),
    .last        (last_s),
    .next_border (next_border_s)
  );

  // State, window counter and captured median result.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_r <= IDLE;
      k_r     <= 4'd0;
      res_r   <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == FETCH) begin
        k_r <= (k_r == 4'd9) ? 4'd0 : (k_r + 4'd1);
      end else begin
        k_r <= 4'd0;
      end
      if ((state_r == WAIT) && MDSO) begin
        res_r <= MDO;
      end
    end
  end

  // Next state; MDSO is only looked at in WAIT since the filter holds a stale valid level.
  always_comb begin
    state_s = state_r;
    clr_s   = 1'b0;
    adv_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (START) begin
          state_s = BRD_RD;
          clr_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BRD_RD: state_s = BRD_WR;
      BRD_WR, WRITE: begin
        if (last_s) begin
          state_s = FIN;
        end else begin
          adv_s   = 1'b1;
          state_s = next_border_s ? BRD_RD : FETCH;
        end
      end
      FETCH: begin
        if (k_r == 4'd9) state_s = WAIT;
        else             state_s = FETCH;
      end
      WAIT: begin
        if (MDSO) state_s = WRITE;
        else      state_s = WAIT;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the registered state and counters.
  always_comb begin
    BUSY  = (state_r != IDLE);
    DONE  = 1'b0;
    WE    = 1'b0;
    MDSI  = 1'b0;
    RADDR = '0;
    WADDR = '0;
    WDATA = '0;
    MDI   = '0;
    case (state_r)
      BRD_RD: RADDR = pix_s;
      BRD_WR: begin
        WE    = 1'b1;
        WADDR = DST_A + pix_s;
        WDATA = RDATA;
      end
      FETCH: begin
        if (k_r <= 4'd8) RADDR = win_s;
        else             RADDR = '0;
        if (k_r != 4'd0) begin
          MDSI = 1'b1;
          MDI  = RDATA;
        end else begin
          MDSI = 1'b0;
          MDI  = '0;
        end
      end
      WRITE: begin
        WE    = 1'b1;
        WADDR = DST_A + pix_s;
        WDATA = res_r;
      end
      FIN:     DONE = 1'b1;
      default: BUSY = (state_r != IDLE);
    endcase
  end

endmodule

// File: tb/tb_median_img_ctrl.sv
// Directed bench: three controller instances (3x3, 4x4, 16x16) each with a RAM model
// and a behavioural median unit that holds a stale valid level while being reloaded.
module tb_median_img_ctrl;

  localparam int NC       = 3;
  localparam int SIZE     = 8;
  localparam int ADDR_W   = 10;
  localparam int DST_BASE = 256;
  localparam int WIN_EXP [9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};

  logic       clk = 1'b0;
  logic       nrst [NC];
  logic       start [NC];
  logic       clr [NC];
  logic       force_mdso [NC];
  int         lat [NC];
  logic [7:0] src [NC][256];
  logic       done_w [NC];
  logic       mdsi_w [NC];
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] med9(input logic [7:0] v [9]);
    logic [7:0] a [9];
    logic [7:0] t;
    a = v;
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return a[4];
  endfunction

  function automatic logic [7:0] exp_pix(input logic [7:0] s [256], input int w, input int h,
                                         input int x, input int y);
    logic [7:0] v [9];
    if (x == 0 || y == 0 || x == w - 1 || y == h - 1) return s[y*w + x];
    for (int i = 0; i < 9; i++) v[i] = s[(y - 1 + i/3)*w + (x - 1 + i%3)];
    return med9(v);
  endfunction

  function automatic int img_errors(input logic [7:0] s [256], input logic [7:0] d [256],
                                    input int w, input int h);
    int e = 0;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        if (d[y*w + x] !== exp_pix(s, w, h, x, y)) e++;
    return e;
  endfunction

  for (genvar g = 0; g < NC; g++) begin : inst
    localparam int CW = (g == 0) ? 3 : ((g == 1) ? 4 : 16);
    logic              busy, done, we, mdsi;
    logic              mdso = 1'b0;
    logic [ADDR_W-1:0] raddr, waddr, raddr_q;
    logic [SIZE-1:0]   rdata, wdata, mdi, mdo;
    logic [SIZE-1:0]   win [9];
    logic [SIZE-1:0]   dst [256];
    logic [ADDR_W-1:0] win_addr [9];
    logic              mdsi_q = 1'b0, mdsi_n = 1'b0, pend = 1'b0;
    int                load_n, idx, zc, run;
    int                we_n, done_n, busy_n, done_at, bad_runs, cap_n;

    median_img_ctrl #(.SIZE(SIZE), .W(CW), .H(CW), .ADDR_W(ADDR_W), .DST_BASE(DST_BASE)) dut (
      .CLK(clk), .nRST(nrst[g]), .START(start[g]), .BUSY(busy), .DONE(done),
      .RADDR(raddr), .RDATA(rdata), .WE(we), .WADDR(waddr), .WDATA(wdata),
      .MDI(mdi), .MDSI(mdsi), .MDO(mdo), .MDSO(mdso)
    );

    assign done_w[g] = done;
    assign mdsi_w[g] = mdsi;
    assign idx       = mdsi_q ? load_n : 0;
    always_comb mdo  = med9(win);

    always @(posedge clk) rdata <= src[g][raddr[7:0]];

    // Median unit: valid drops after the 9th load and rises in the lat-th idle cycle.
    always @(posedge clk) begin
      mdsi_q <= mdsi;
      if (mdsi === 1'b1) begin
        if (idx < 9) win[idx] <= mdi;
        load_n <= idx + 1;
        zc     <= 0;
        pend   <= 1'b1;
        mdso   <= (idx == 8) ? 1'b0 : (mdso | force_mdso[g]);
      end else if (pend) begin
        zc <= zc + 1;
        if (zc + 2 == lat[g]) begin mdso <= 1'b1; pend <= 1'b0; end
      end
    end

    always @(negedge clk) begin
      raddr_q <= raddr;
      mdsi_n  <= mdsi;
      if (clr[g]) begin
        we_n <= 0; done_n <= 0; busy_n <= 0; done_at <= -1;
        bad_runs <= 0; run <= 0; cap_n <= 0;
        for (int i = 0; i < 256; i++) dst[i] <= 'x;
      end else begin
        if (busy) busy_n <= busy_n + 1;
        if (done) begin done_n <= done_n + 1; done_at <= busy_n; end
        if (we) begin
          we_n <= we_n + 1;
          if (waddr >= ADDR_W'(DST_BASE)) dst[8'(waddr - ADDR_W'(DST_BASE))] <= wdata;
        end
        run <= mdsi ? run + 1 : 0;
        if (!mdsi && mdsi_n && run != 9) bad_runs <= bad_runs + 1;
        if (mdsi && cap_n < 9) begin win_addr[cap_n] <= raddr_q; cap_n <= cap_n + 1; end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear(input int g);
    clr[g] = 1'b1;
    repeat (2) @(negedge clk);
    clr[g] = 1'b0;
  endtask

  task automatic pulse_start(input int g, input int n);
    start[g] = 1'b1;
    repeat (n) @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic run_done(input int g, input int budget, input string tag);
    int c = 0;
    while (done_w[g] !== 1'b1 && c < budget) begin @(negedge clk); c++; end
    check(tag, done_w[g], 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_mdsi(input int g, input logic lvl, input int budget, input string tag);
    int c = 0;
    while (mdsi_w[g] !== lvl && c < budget) begin @(negedge clk); c++; end
    check(tag, mdsi_w[g], lvl);
  endtask

  initial begin
    for (int g = 0; g < NC; g++) begin
      nrst[g] = 1'b0; start[g] = 1'b0; clr[g] = 1'b0; force_mdso[g] = 1'b0; lat[g] = 3;
    end
    for (int i = 0; i < 256; i++) begin
      src[0][i] = (i == 4) ? 8'd200 : 8'd5;
      src[1][i] = 8'($urandom);
      src[2][i] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    check("rst_ctl", {inst[0].busy, inst[0].done, inst[0].we, inst[0].mdsi}, 0);
    check("rst_raddr", inst[0].raddr, 0);
    check("rst_waddr", inst[0].waddr, 0);
    check("rst_wdata", inst[0].wdata, 0);
    check("rst_mdi", inst[0].mdi, 0);
    for (int g = 0; g < NC; g++) nrst[g] = 1'b1;
    for (int g = 0; g < NC; g++) clear(g);

    // 3x3: one interior pixel with a slow median unit
    lat[0] = 42;
    pulse_start(0, 1);
    run_done(0, 500, "done3");
    check("busy_cyc3", inst[0].done_at, 69);
    check("center3", inst[0].dst[4], 5);
    check("img3", img_errors(src[0], inst[0].dst, 3, 3), 0);
    check("we3", inst[0].we_n, 9);
    check("donecnt3", inst[0].done_n, 1);

    // 4x4 random image
    pulse_start(1, 1);
    run_done(1, 1000, "done4");
    for (int i = 0; i < 16; i++)
      check($sformatf("px4_%0d", i), inst[1].dst[i], exp_pix(src[1], 4, 4, i % 4, i / 4));
    check("we4", inst[1].we_n, 16);
    check("runs4", inst[1].bad_runs, 0);

    // 16x16: START held, extra START mid-run, valid forced high while loading
    force_mdso[2] = 1'b1;
    pulse_start(2, 3);
    repeat (200) @(negedge clk);
    pulse_start(2, 1);
    run_done(2, 20000, "done16");
    repeat (20) @(negedge clk);
    check("donecnt16", inst[2].done_n, 1);
    check("idle16", inst[2].busy, 0);
    check("we16", inst[2].we_n, 256);
    check("img16", img_errors(src[2], inst[2].dst, 16, 16), 0);
    check("runs16", inst[2].bad_runs, 0);
    for (int i = 0; i < 9; i++)
      check($sformatf("win%0d", i), inst[2].win_addr[i], WIN_EXP[i]);

    // Reset while waiting on the first interior median, then a clean restart
    force_mdso[2] = 1'b0;
    lat[2] = 20;
    clear(2);
    pulse_start(2, 1);
    wait_mdsi(2, 1'b1, 200, "mdsi_rise");
    wait_mdsi(2, 1'b0, 50, "mdsi_fall");
    repeat (3) @(negedge clk);
    nrst[2] = 1'b0;
    @(negedge clk);
    check("rstw_busy", inst[2].busy, 0);
    check("rstw_we", inst[2].we, 0);
    nrst[2] = 1'b1;
    repeat (40) @(negedge clk);
    check("rstw_writes", inst[2].we_n, 17);
    check("rstw_idle", inst[2].busy, 0);
    lat[2] = 3;
    clear(2);
    pulse_start(2, 1);
    run_done(2, 20000, "done16b");
    check("img16b", img_errors(src[2], inst[2].dst, 16, 16), 0);
    check("we16b", inst[2].we_n, 256);
    check("donecnt16b", inst[2].done_n, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
